pixel_addr_gen: RTL and testbench



---
 rtl/pixel_addr_gen.sv | 140 ++++++++++++++
 tb/tb_pixel_addr_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_addr_gen.sv
// Purpose: drop off-screen pixels, map (x,y) to a linear framebuffer word address, queue {addr,color}.
// Latency: in_valid at cycle N -> out_valid at N+2 when the queue is empty; off-screen pixels are never emitted.
// Backpressure: out_valid/out_ready pop; in_ready reserves room for the converter's in-flight pixel; a push into a full queue with no pop is lost (overflow).
module pixel_addr_gen #(
  parameter int              SCREEN_W   = 640,
  parameter int              SCREEN_H   = 480,
  parameter longint unsigned FB_BASE    = 0,
  parameter int              ADDR_W     = 32,
  parameter int              COLOR_W    = 32,
  parameter int              FIFO_DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [31:0]        x_int,
  input  logic [31:0]        y_int,
  input  logic [COLOR_W-1:0] color,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [COLOR_W-1:0] out_color,
  output logic [15:0]        drop_cnt,
  output logic               overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);

  // Stage S1 registers
  logic               r_s1_vld;
  logic               r_s1_on;
  logic [ADDR_W-1:0]  r_s1_row;
  logic [ADDR_W-1:0]  r_s1_x;
  logic [COLOR_W-1:0] r_s1_color;

  // Output queue state
  logic [ADDR_W-1:0]  r_mem_addr  [FIFO_DEPTH];
  logic [COLOR_W-1:0] r_mem_color [FIFO_DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [PW:0]        r_count;
  logic [15:0]        r_drop_cnt;
  logic               r_overflow;

  // Combinational helpers
  logic signed [31:0] w_x_s;
  logic signed [31:0] w_y_s;
  logic               w_onscreen;
  logic [ADDR_W-1:0]  w_row;
  logic [ADDR_W-1:0]  w_x_a;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_push_req;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic [PW+1:0]      w_occ;

  assign w_x_s = $signed(x_int);
  assign w_y_s = $signed(y_int);

  // Signed bounds test: negative coordinates must reject, not wrap to large unsigned values.
  assign w_onscreen = (w_x_s >= 0) && (w_x_s < SCREEN_W) &&
                      (w_y_s >= 0) && (w_y_s < SCREEN_H);

  // Multiply at ADDR_W width: the result is y*SCREEN_W modulo 2^ADDR_W.
  assign w_row = ADDR_W'(w_y_s) * ADDR_W'(SCREEN_W);
  assign w_x_a = ADDR_W'(w_x_s);

  assign w_addr     = ADDR_W'(FB_BASE) + r_s1_row + r_s1_x;
  assign w_push_req = r_s1_vld && r_s1_on;
  assign w_full     = (r_count == (PW+1)'(FIFO_DEPTH));
  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid && out_ready;
  // A pop in the same cycle frees the head slot, so a full queue still accepts the push.
  assign w_push     = w_push_req && (!w_full || w_pop);

  // Counts the queued entries plus the pixel in S1 and the one the converter is emitting now.
  assign w_occ    = (PW+2)'(r_count) + (PW+2)'(r_s1_vld) + (PW+2)'(in_valid);
  assign in_ready = (w_occ <= (PW+2)'(FIFO_DEPTH - 2));

  assign out_addr  = out_valid ? r_mem_addr[r_rd_ptr]  : '0;
  assign out_color = out_valid ? r_mem_color[r_rd_ptr] : '0;
  assign drop_cnt  = r_drop_cnt;
  assign overflow  = r_overflow;

  // S1 capture: bounds check and row product registered alongside the pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_on    <= 1'b0;
      r_s1_row   <= '0;
      r_s1_x     <= '0;
      r_s1_color <= '0;
    end else begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_on    <= w_onscreen;
        r_s1_row   <= w_row;
        r_s1_x     <= w_x_a;
        r_s1_color <= color;
      end
    end
  end

  // Queue storage: no reset needed, outputs are masked while empty.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr]  <= w_addr;
      r_mem_color[r_wr_ptr] <= r_s1_color;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Status: saturating off-screen count and sticky lost-pixel flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (r_s1_vld && !r_s1_on && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_push_req && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_addr_gen.sv
module tb_pixel_addr_gen;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] color;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] x_int;
  logic [31:0] y_int;
  logic [31:0] color;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_color;
  logic [15:0] drop_cnt;
  logic        overflow;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   mcount, ms1, nxt_s1, issued;

  pixel_addr_gen dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .x_int     (x_int),
    .y_int     (y_int),
    .color     (color),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_color (out_color),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one converter result; optionally record the hand-computed expected output.
  task automatic pix(input int x, input int y, input logic [31:0] c,
                     input bit exp_push, input logic [31:0] exp_addr);
    x_int    = 32'(x);
    y_int    = 32'(y);
    color    = c;
    in_valid = 1'b1;
    if (exp_push) sb_q.push_back('{addr: exp_addr, color: c});
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0 && !out_valid) break;
      step();
    end
    check(nm, 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: compare every accepted head against the scoreboard, away from the clock edge.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got addr=0x%0h, required no output", out_addr);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_addr", 64'(out_addr), 64'(e.addr));
        check("sb_color", 64'(out_color), 64'(e.color));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_int     = '0;
    y_int     = '0;
    color     = '0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    step();
    reset_n = 1'b1;
    step();

    // Basic latency: (10,20) -> 20*640+10
    out_ready = 1'b1;
    pix(10, 20, 32'hFF00FF00, 1'b1, 32'd12810);
    step();
    in_valid = 1'b0;
    check("lat_n1_valid", 64'(out_valid), 64'd0);
    step();
    check("lat_n2_valid", 64'(out_valid), 64'd1);
    check("lat_n2_addr", 64'(out_addr), 64'd12810);
    check("lat_n2_color", 64'(out_color), 64'hFF00FF00);
    step();
    check("lat_n3_valid", 64'(out_valid), 64'd0);

    // Screen boundaries
    pix(-1, 5, 32'h11, 1'b0, 32'd0);          step();
    pix(640, 0, 32'h22, 1'b0, 32'd0);         step();
    pix(0, 480, 32'h33, 1'b0, 32'd0);         step();
    pix(639, 479, 32'h44, 1'b1, 32'd307199);  step();
    in_valid = 1'b0;
    repeat (4) step();
    check("bnd_drop_cnt", 64'(drop_cnt), 64'd3);
    check("bnd_overflow", 64'(overflow), 64'd0);
    wait_drain("bnd_drain");

    // Flow control: upstream obeys in_ready with the writer stalled
    out_ready = 1'b0;
    mcount = 0; ms1 = 0; issued = 0;
    for (int c = 0; c < 16; c++) begin
      x_int    = 32'(issued);
      y_int    = 32'd0;
      color    = 32'hC000_0000 + 32'(issued);
      in_valid = 1'b1;
      #1;
      check("fc_in_ready", 64'(in_ready), 64'((mcount + ms1 + 1) <= 6));
      if (in_ready) begin
        sb_q.push_back('{addr: 32'(issued), color: color});
        issued++;
        nxt_s1 = 1;
      end else begin
        in_valid = 1'b0;
        nxt_s1 = 0;
      end
      mcount = mcount + ms1;
      ms1 = nxt_s1;
      step();
    end
    in_valid = 1'b0;
    check("fc_issued", 64'(issued), 64'd6);
    check("fc_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    wait_drain("fc_drain");

    // Forced overflow: ninth pixel lost
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pix(i, 1, 32'hA000_0000 + 32'(i), (i < 8), 32'd640 + 32'(i));
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_drop_cnt", 64'(drop_cnt), 64'd3);
    check("ovf_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Full queue with simultaneous push and pop every cycle
    reset_n = 1'b0;
    sb_q.delete();
    step();
    reset_n = 1'b1;
    out_ready = 1'b0;
    step();
    check("full_pre_overflow", 64'(overflow), 64'd0);
    check("full_pre_drop", 64'(drop_cnt), 64'd0);
    for (int c = 0; c < 15; c++) begin
      if (c == 9) out_ready = 1'b1;
      if (c >= 9) check("full_out_valid", 64'(out_valid), 64'd1);
      pix(c, 2, 32'hB000_0000 + 32'(c), 1'b1, 32'd1280 + 32'(c));
      step();
    end
    in_valid = 1'b0;
    step();
    check("full_overflow", 64'(overflow), 64'd0);
    wait_drain("full_drain");

    // Reset mid-operation with queued entries and S1 occupied
    out_ready = 1'b0;
    pix(-5, 0, 32'h55, 1'b0, 32'd0);
    step();
    for (int i = 0; i < 6; i++) begin
      pix(i, 3, 32'hD000_0000 + 32'(i), 1'b1, 32'd1920 + 32'(i));
      step();
    end
    in_valid = 1'b0;
    check("mid_pre_drop", 64'(drop_cnt), 64'd1);
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_drop", 64'(drop_cnt), 64'd0);
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    pix(1, 1, 32'h0BADF00D, 1'b1, 32'd641);
    step();
    in_valid = 1'b0;
    step();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_addr", 64'(out_addr), 64'd641);
    wait_drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
